// File: rtl/spi_flash_cmd.sv
// Flash command sequencer feeding spi_master: frames opcode/address/data bytes under nCS_ctrl.
// Optional SPI_FLASH_WIP_POLL_EN: after program/erase, poll READ_STATUS until WIP clears before done.
module spi_flash_cmd #(
    parameter int CS_SETUP = 2,
    parameter int CS_HOLD  = 2,
    parameter int CS_GAP   = 4
) (
    input  logic        sys_clk,
    input  logic        rst,
    input  logic        cmd_valid,
    input  logic [2:0]  cmd_op,
    input  logic [23:0] cmd_addr,
    input  logic [7:0]  cmd_len,
    input  logic [7:0]  wdata,
    input  logic        wdata_valid,
    output logic        wdata_ready,
    output logic [7:0]  rdata,
    output logic        rdata_valid,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic        nCS_ctrl,
    output logic        wr_req,
    output logic [7:0]  data_in,
    input  logic        wr_ack,
    input  logic [7:0]  data_recv
);

    localparam logic [2:0] OP_RDID = 3'd0, OP_READ = 3'd1, OP_WREN = 3'd2,
                           OP_PP   = 3'd3, OP_SE   = 3'd4, OP_RDSR = 3'd5;
    localparam logic [8:0] SETUP_LAST = 9'(CS_SETUP - 1);
    localparam logic [8:0] HOLD_LAST  = 9'(CS_HOLD - 1);
    localparam logic [8:0] GAP_LAST   = 9'(CS_GAP - 1);
    localparam logic [8:0] GAP_DONE   = 9'(CS_GAP - 2);

    typedef enum logic [2:0] {IDLE, SETUP, OPC, ADDR, DATA, HOLD, GAP, ERR} state_t;

    state_t      state;
    logic [2:0]  op;
    logic [23:0] addr;
    logic [8:0]  last;
    logic [8:0]  cnt;
    logic        poll;
    logic        has_addr, has_data, need_poll;
    logic [7:0]  opcode, addr_byte;

    always_comb begin
        has_addr  = (op == OP_READ) || (op == OP_PP) || (op == OP_SE);
        has_data  = !((op == OP_WREN) || (op == OP_SE));
        opcode    = 8'h00;
        case (op)
            OP_RDID: opcode = 8'h9F;
            OP_READ: opcode = 8'h03;
            OP_WREN: opcode = 8'h06;
            OP_PP:   opcode = 8'h02;
            OP_SE:   opcode = 8'h20;
            OP_RDSR: opcode = 8'h05;
            default: opcode = 8'h00;
        endcase
        case (cnt[1:0])
            2'd0:    addr_byte = addr[23:16];
            2'd1:    addr_byte = addr[15:8];
            default: addr_byte = addr[7:0];
        endcase
    end

`ifdef SPI_FLASH_WIP_POLL_EN
    logic wip;
    // First completion of program/erase always polls; afterwards keep polling while WIP is set.
    assign need_poll = poll ? wip : ((op == OP_PP) || (op == OP_SE));
`else
    assign need_poll = 1'b0;
`endif

    // Same-cycle acknowledge so the requester can advance wdata on the consuming edge.
    assign wdata_ready = !rst && (state == DATA) && (op == OP_PP) && !wr_req && wdata_valid;

    always_ff @(posedge sys_clk) begin
        if (rst) begin
            state       <= IDLE;
            op          <= OP_RDID;
            addr        <= '0;
            last        <= '0;
            cnt         <= '0;
            poll        <= 1'b0;
            nCS_ctrl    <= 1'b1;
            wr_req      <= 1'b0;
            data_in     <= 8'h00;
            rdata       <= 8'h00;
            rdata_valid <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            err         <= 1'b0;
`ifdef SPI_FLASH_WIP_POLL_EN
            wip         <= 1'b0;
`endif
        end else begin
            rdata_valid <= 1'b0;
            case (state)
                IDLE: if (cmd_valid) begin
                    op   <= cmd_op;
                    addr <= cmd_addr;
                    cnt  <= '0;
                    poll <= 1'b0;
                    busy <= 1'b1;
                    case (cmd_op)
                        OP_RDID:       last <= 9'd2;
                        OP_READ, OP_PP: last <= {1'b0, cmd_len};
                        default:       last <= 9'd0;
                    endcase
                    if (cmd_op > OP_RDSR) begin
                        done  <= 1'b1;
                        err   <= 1'b1;
                        state <= ERR;
                    end else begin
                        nCS_ctrl <= 1'b0;
                        state    <= SETUP;
                    end
                end
                ERR: begin
                    done  <= 1'b0;
                    err   <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                SETUP: if (cnt == SETUP_LAST) begin
                    cnt     <= '0;
                    wr_req  <= 1'b1;
                    data_in <= opcode;
                    state   <= OPC;
                end else cnt <= cnt + 9'd1;
                OPC: if (wr_req && wr_ack) begin
                    wr_req <= 1'b0;
                    cnt    <= '0;
                    state  <= has_addr ? ADDR : (has_data ? DATA : HOLD);
                end
                ADDR: if (wr_req) begin
                    if (wr_ack) begin
                        wr_req <= 1'b0;
                        if (cnt == 9'd2) begin
                            cnt   <= '0;
                            state <= has_data ? DATA : HOLD;
                        end else cnt <= cnt + 9'd1;
                    end
                end else begin
                    wr_req  <= 1'b1;
                    data_in <= addr_byte;
                end
                DATA: if (wr_req) begin
                    if (wr_ack) begin
                        wr_req <= 1'b0;
                        if (op != OP_PP) begin
                            if (!poll) begin
                                rdata       <= data_recv;
                                rdata_valid <= 1'b1;
                            end
`ifdef SPI_FLASH_WIP_POLL_EN
                            wip <= data_recv[0];
`endif
                        end
                        if (cnt == last) begin
                            cnt   <= '0;
                            state <= HOLD;
                        end else cnt <= cnt + 9'd1;
                    end
                end else if (op == OP_PP) begin
                    if (wdata_valid) begin
                        wr_req  <= 1'b1;
                        data_in <= wdata;
                    end
                end else begin
                    wr_req  <= 1'b1;
                    data_in <= 8'h00;
                end
                HOLD: if (cnt == HOLD_LAST) begin
                    cnt      <= '0;
                    nCS_ctrl <= 1'b1;
                    state    <= GAP;
                end else cnt <= cnt + 9'd1;
                GAP: begin
                    if (cnt == GAP_DONE) done <= !need_poll;
                    if (cnt == GAP_LAST) begin
                        done <= 1'b0;
                        cnt  <= '0;
                        if (need_poll) begin
                            op       <= OP_RDSR;
                            last     <= 9'd0;
                            poll     <= 1'b1;
                            nCS_ctrl <= 1'b0;
                            state    <= SETUP;
                        end else begin
                            busy  <= 1'b0;
                            state <= IDLE;
                        end
                    end else cnt <= cnt + 9'd1;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_flash_cmd.sv
// Scoreboard bench for spi_flash_cmd with a behavioural spi_master responder and wdata source.
module tb_spi_flash_cmd;

    logic        sys_clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_valid = 1'b0;
    logic [2:0]  cmd_op = '0;
    logic [23:0] cmd_addr = '0;
    logic [7:0]  cmd_len = '0;
    logic [7:0]  wdata = '0;
    logic        wdata_valid = 1'b0;
    logic        wdata_ready;
    logic [7:0]  rdata;
    logic        rdata_valid, busy, done, err, nCS_ctrl, wr_req;
    logic [7:0]  data_in;
    logic        wr_ack = 1'b0;
    logic [7:0]  data_recv = '0;

    spi_flash_cmd dut (
        .sys_clk(sys_clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_op(cmd_op),
        .cmd_addr(cmd_addr), .cmd_len(cmd_len), .wdata(wdata), .wdata_valid(wdata_valid),
        .wdata_ready(wdata_ready), .rdata(rdata), .rdata_valid(rdata_valid), .busy(busy),
        .done(done), .err(err), .nCS_ctrl(nCS_ctrl), .wr_req(wr_req), .data_in(data_in),
        .wr_ack(wr_ack), .data_recv(data_recv)
    );

    always #5 sys_clk = ~sys_clk;

    typedef struct { logic err; int frames; } done_t;

    int total = 0, bad = 0;
    logic [7:0] exp_wire[$], slave_q[$], exp_rd[$], wd_q[$], forced[$], poll_resp[$];
    done_t exp_done[$];
    int frames_seen = 0, ack_cnt = 0, rdy_cnt = 0, sl_dly = 0;
    int wd_stall = 0, wd_stall_after = 0;
    bit stray_en = 1'b0;
    logic prev_cs = 1'b1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] opc(input logic [2:0] op);
        logic [7:0] tbl [6] = '{8'h9F, 8'h03, 8'h06, 8'h02, 8'h20, 8'h05};
        return tbl[op];
    endfunction

    function automatic int nbytes(input logic [2:0] op, input logic [7:0] len);
        case (op)
            3'd0:       return 3;
            3'd1, 3'd3: return int'(len) + 1;
            3'd5:       return 1;
            default:    return 0;
        endcase
    endfunction

    // spi_master stand-in: acks each request after 0-2 idle cycles, checks the byte on the wire.
    always @(negedge sys_clk) begin
        if (rst) begin
            wr_ack = 1'b0;
            sl_dly = 0;
        end else if (wr_ack) begin
            wr_ack = 1'b0;
        end else if (wr_req) begin
            if (sl_dly > 0) sl_dly--;
            else begin
                if (exp_wire.size() == 0) chk("wire_extra", 1, 0);
                else chk("wire_byte", data_in, exp_wire.pop_front());
                chk("cs_during_req", nCS_ctrl, 0);
                data_recv = (slave_q.size() != 0) ? slave_q.pop_front() : 8'h00;
                wr_ack = 1'b1;
                ack_cnt++;
                sl_dly = $urandom_range(0, 2);
            end
        end else if (stray_en && $urandom_range(0, 15) == 0) begin
            wr_ack = 1'b1;
            data_recv = 8'($urandom);
        end
    end

    // Program-data source with random gaps and an optional long stall after the first byte.
    always @(negedge sys_clk) begin
        if (rst) wdata_valid = 1'b0;
        else if (wd_stall > 0) begin
            if (wd_stall < 5) begin
                chk("stall_cs_low", nCS_ctrl, 0);
                chk("stall_req_low", wr_req, 0);
            end
            wd_stall--;
            wdata_valid = 1'b0;
        end else if (wd_q.size() != 0) begin
            wdata_valid = ($urandom_range(0, 3) != 0);
            wdata = wd_q[0];
        end else wdata_valid = 1'b0;
        #4;
        if (!rst && wdata_valid && wdata_ready) begin
            if (wd_q.size() != 0) void'(wd_q.pop_front());
            else chk("wdata_extra", 1, 0);
            rdy_cnt++;
            wd_stall = wd_stall_after;
            wd_stall_after = 0;
        end
    end

    // Response monitor.
    always @(negedge sys_clk) begin
        done_t d;
        if (rst) begin
            frames_seen = 0;
            prev_cs = 1'b1;
        end else begin
            if (!nCS_ctrl && prev_cs) frames_seen++;
            prev_cs = nCS_ctrl;
            if (rdata_valid) begin
                if (exp_rd.size() == 0) chk("rdata_extra", 1, 0);
                else chk("rdata", rdata, exp_rd.pop_front());
            end
            if (err && !done) chk("err_without_done", 1, 0);
            if (done) begin
                if (exp_done.size() == 0) chk("done_extra", 1, 0);
                else begin
                    d = exp_done.pop_front();
                    chk("done_err", err, d.err);
                    chk("cs_frames", frames_seen, d.frames);
                    chk("rdata_missing", exp_rd.size(), 0);
                end
                frames_seen = 0;
            end
        end
    end

    task automatic issue(input logic [2:0] op, input logic [23:0] a, input logic [7:0] len,
                         input int stall2);
        done_t t;
        int n;
        logic [31:0] rv;
        t.err = (op > 3'd5);
        t.frames = 0;
        if (!t.err) begin
            t.frames = 1;
            exp_wire.push_back(opc(op));
            rv = $urandom; slave_q.push_back(rv[7:0]);
            if (op == 3'd1 || op == 3'd3 || op == 3'd4)
                for (int i = 2; i >= 0; i--) begin
                    exp_wire.push_back(a[8*i +: 8]);
                    rv = $urandom; slave_q.push_back(rv[7:0]);
                end
            n = nbytes(op, len);
            for (int i = 0; i < n; i++) begin
                rv = $urandom;
                if (op == 3'd3) begin
                    wd_q.push_back(rv[7:0]);
                    exp_wire.push_back(rv[7:0]);
                    rv = $urandom; slave_q.push_back(rv[7:0]);
                end else begin
                    if (forced.size() != 0) rv[7:0] = forced.pop_front();
                    exp_wire.push_back(8'h00);
                    slave_q.push_back(rv[7:0]);
                    exp_rd.push_back(rv[7:0]);
                end
            end
`ifdef SPI_FLASH_WIP_POLL_EN
            if (op == 3'd3 || op == 3'd4) begin
                int k;
                k = (poll_resp.size() != 0) ? poll_resp.size() : $urandom_range(1, 3);
                for (int j = 0; j < k; j++) begin
                    exp_wire.push_back(8'h05);
                    exp_wire.push_back(8'h00);
                    rv = $urandom; slave_q.push_back(rv[7:0]);
                    rv = $urandom;
                    if (poll_resp.size() != 0) rv[7:0] = poll_resp.pop_front();
                    else rv[0] = (j < k - 1);
                    slave_q.push_back(rv[7:0]);
                    t.frames++;
                end
            end
`endif
        end
        exp_done.push_back(t);
        wd_stall_after = stall2;
        @(negedge sys_clk);
        cmd_valid = 1'b1; cmd_op = op; cmd_addr = a; cmd_len = len;
        @(negedge sys_clk);
        cmd_valid = 1'b0;
        if (t.err) chk("illegal_done_err", {30'd0, done, err}, 32'd3);
    endtask

    task automatic wait_idle(input bit junk);
        int c = 0;
        while ((exp_done.size() != 0 || busy) && c < 6000) begin
            @(negedge sys_clk);
            c++;
            cmd_valid = junk && busy && ($urandom_range(0, 15) == 0);
            if (cmd_valid) begin
                cmd_op = 3'($urandom); cmd_addr = 24'($urandom); cmd_len = 8'($urandom);
            end
        end
        cmd_valid = 1'b0;
        if (c >= 6000) begin
            total++; bad++;
            $display("FAIL timeout: busy=%0d pending_done=%0d after %0d cycles", busy, exp_done.size(), c);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int base, c;
        repeat (3) @(posedge sys_clk);
        #1;
        chk("rst_ncs", nCS_ctrl, 1);      chk("rst_wr_req", wr_req, 0);
        chk("rst_data_in", data_in, 0);   chk("rst_wdata_ready", wdata_ready, 0);
        chk("rst_rdata", rdata, 0);       chk("rst_rdata_valid", rdata_valid, 0);
        chk("rst_busy", busy, 0);         chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        @(negedge sys_clk) rst = 1'b0;

        forced = '{8'hEF, 8'h40, 8'h18};
        issue(3'd0, 24'h0, 8'd0, 0);                wait_idle(0);
        issue(3'd1, 24'h012345, 8'd3, 0);           wait_idle(0);
        base = rdy_cnt;
        issue(3'd3, 24'h00A5C3, 8'd1, 10);          wait_idle(0);
        chk("wdata_ready_pulses", rdy_cnt - base, 2);
        issue(3'd7, 24'h0, 8'd0, 0);                wait_idle(0);
        issue(3'd6, 24'h0, 8'd0, 0);                wait_idle(0);

        // Reset in the middle of the address phase of a READ.
        base = ack_cnt;
        issue(3'd1, 24'h0F0F0F, 8'd3, 0);
        c = 0;
        while (ack_cnt < base + 2 && c < 1000) begin @(negedge sys_clk); c++; end
        chk("reach_addr_phase", (c < 1000), 1);
        rst = 1'b1;
        @(posedge sys_clk); #1;
        chk("abort_ncs", nCS_ctrl, 1); chk("abort_wr_req", wr_req, 0);
        chk("abort_busy", busy, 0);    chk("abort_done", done, 0);
        exp_wire.delete(); slave_q.delete(); exp_rd.delete(); exp_done.delete(); wd_q.delete();
        wd_stall = 0; wd_stall_after = 0;
        @(negedge sys_clk);
        @(negedge sys_clk) rst = 1'b0;
        issue(3'd2, 24'h0, 8'd0, 0);                wait_idle(0);

        issue(3'd1, 24'h7FFFFF, 8'd0, 0);           wait_idle(0);
        issue(3'd3, 24'h100000, 8'd255, 0);         wait_idle(0);
        issue(3'd1, 24'hFFFF00, 8'd255, 0);         wait_idle(0);
        issue(3'd5, 24'h0, 8'd0, 0);                wait_idle(0);
        issue(3'd4, 24'h321000, 8'd0, 0);           wait_idle(0);
`ifdef SPI_FLASH_WIP_POLL_EN
        poll_resp = '{8'h01, 8'h01, 8'h00};
        issue(3'd4, 24'hABCDEF, 8'd0, 0);           wait_idle(0);
`endif

        stray_en = 1'b1;
        for (int i = 0; i < 40; i++) begin
            issue(3'($urandom_range(0, 7)), 24'($urandom), 8'($urandom_range(0, 6)), 0);
            wait_idle(1);
        end
        stray_en = 1'b0;
        repeat (10) @(negedge sys_clk);
        chk("queues_drained", exp_wire.size() + exp_rd.size() + exp_done.size() + wd_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/spi_flash_cmd.md
Name: spi_flash_cmd

Overview:
Command sequencer directly upstream of spi_master. Turns one flash-level request (opcode, 24-bit address, length) into the byte stream spi_master shifts out. Drives spi_master's nCS_ctrl, wr_req and data_in. Consumes its wr_ack and data_recv, and returns read bytes to the requester as a valid-pulsed stream.

Parameters:
CS_SETUP, 2, sys_clk cycles nCS_ctrl is held low before the first wr_req.
CS_HOLD, 2, sys_clk cycles after the last wr_ack before nCS_ctrl returns high.
CS_GAP, 4, minimum sys_clk cycles nCS_ctrl stays high before the next command may start.

Ports:
sys_clk  in  1  system clock; all logic on its rising edge
rst  in  1  synchronous reset, active-high
cmd_valid  in  1  request strobe; sampled only while busy=0
cmd_op  in  3  0 READ_ID, 1 READ, 2 WREN, 3 PAGE_PROG, 4 SECTOR_ERASE, 5 READ_STATUS, 6-7 illegal
cmd_addr  in  24  flash byte address, sent MSB byte first
cmd_len  in  8  data byte count minus 1 (0 means 1 byte, 255 means 256 bytes); used by READ and PAGE_PROG only
wdata  in  8  program data byte
wdata_valid  in  1  wdata holds a valid byte
wdata_ready  out  1  1-cycle pulse: wdata consumed this cycle
rdata  out  8  received data byte
rdata_valid  out  1  1-cycle pulse per received data byte
busy  out  1  command in progress
done  out  1  1-cycle pulse at command completion
err  out  1  1-cycle pulse, together with done, for an illegal cmd_op
nCS_ctrl  out  1  chip select to spi_master; 0 = selected
wr_req  out  1  byte transfer request to spi_master
data_in  out  8  byte to transmit
wr_ack  in  1  spi_master 1-cycle pulse: byte finished, data_recv valid
data_recv  in  8  byte received by spi_master

Behaviour:
- Reset values: nCS_ctrl=1, wr_req=0, data_in=0, wdata_ready=0, rdata=0, rdata_valid=0, busy=0, done=0, err=0; FSM in IDLE. A reset mid-command aborts it; nCS_ctrl is 1 the cycle after rst is sampled, and no done pulse is issued.
- FSM states: IDLE -> SETUP -> OPC -> ADDR -> DATA -> HOLD -> GAP -> IDLE.
- IDLE: on cmd_valid, latch cmd_op, cmd_addr and cmd_len, and set busy=1 next cycle.
  - Illegal op: done=1 and err=1 one cycle after acceptance, busy back to 0, and nCS_ctrl never drops.
- SETUP: nCS_ctrl=0 for CS_SETUP cycles.
- Byte handshake: raise wr_req with data_in stable, and hold both until wr_ack. Drop wr_req the cycle after wr_ack. wr_req stays 0 for at least 1 cycle between bytes.
- Opcodes sent in OPC: 0x9F, 0x03, 0x06, 0x02, 0x20, 0x05.
- ADDR: 3 bytes, addr[23:16], then [15:8], then [7:0]. Used for READ, PAGE_PROG and SECTOR_ERASE only.
- DATA phase, per op:
  - READ_ID: 3 bytes.
  - READ_STATUS: 1 byte.
  - READ and PAGE_PROG: cmd_len+1 bytes, counted with a 9-bit counter.
  - WREN and SECTOR_ERASE: no DATA phase.
- Read ops: data_in=0x00 during DATA. On each wr_ack, rdata<=data_recv and rdata_valid=1 in the following cycle.
  - Bytes received during OPC/ADDR are discarded, with no rdata_valid.
- PAGE_PROG: a byte is loaded only when wdata_valid=1; wdata_ready pulses in that cycle and wr_req rises next cycle.
  - If wdata_valid=0, stall with nCS_ctrl held low and wr_req=0 indefinitely.
- HOLD: CS_HOLD cycles with nCS_ctrl=0, then nCS_ctrl=1.
- GAP: CS_GAP cycles with nCS_ctrl=1. done pulses in the last GAP cycle, and busy=0 the cycle after.
- cmd_valid while busy=1 is ignored, not queued.
- A wr_ack arriving while wr_req=0 is ignored.

Optional Feature:
Macro SPI_FLASH_WIP_POLL_EN.
- Defined: after PAGE_PROG or SECTOR_ERASE completes GAP, run an internal READ_STATUS (full SETUP..GAP framing). If data_recv bit0 (WIP) = 1, repeat. done pulses only after a status with bit0=0. Poll status bytes do not raise rdata_valid.
- Undefined: done follows the first GAP directly, and the requester must poll with READ_STATUS itself.

Test Plan:
- READ_ID; bench spi_master model returns 0xEF,0x40,0x18 -> wire bytes 0x9F,0x00,0x00,0x00; rdata_valid pulses 3 times with 0xEF,0x40,0x18; one done; nCS_ctrl low for one continuous span.
- READ addr=0x012345, len=3 -> wire bytes 0x03,0x01,0x23,0x45, then 4 dummy bytes; exactly 4 rdata_valid pulses.
- PAGE_PROG len=1 with wdata_valid withheld 10 cycles before the 2nd byte -> nCS_ctrl stays 0 and wr_req stays 0 during the stall; 2 wdata_ready pulses; wire bytes 0x02, addr, d0, d1.
- cmd_op=7 -> done and err pulse together 1 cycle after acceptance; nCS_ctrl never 0.
- rst asserted during the ADDR phase of a READ -> next cycle nCS_ctrl=1, wr_req=0, busy=0; no done; a following WREN sends only 0x06.
- SPI_FLASH_WIP_POLL_EN defined, SECTOR_ERASE, status returns 0x01,0x01,0x00 -> 3 status frames (each 0x05 + 1 byte); done after the third; no rdata_valid.
